// File: rtl/math_log2_pipe.sv
// rtl/math_log2_pipe.sv - pipelined fixed-point log2 (priority encode + mantissa squaring) with valid/ready
// Optional build macro MATH_LOG2_ROUND_EN: one extra fraction bit plus a half-up rounding stage.
module math_log2_pipe #(
    parameter int  DIN_WIDTH  = 64,
    parameter int  FRAC_WIDTH = 4,
    parameter int  MANT_WIDTH = 16,
    localparam int INT_WIDTH  = $clog2(DIN_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            din_valid,
    output logic                            din_ready,
    input  logic [DIN_WIDTH-1:0]            din,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [INT_WIDTH+FRAC_WIDTH-1:0] dout,
    output logic                            dout_zero
);

    localparam int OUT_W = INT_WIDTH + FRAC_WIDTH;
`ifdef MATH_LOG2_ROUND_EN
    localparam int NBITS = FRAC_WIDTH + 1;
`else
    localparam int NBITS = FRAC_WIDTH;
`endif

    logic w_adv;
    assign w_adv     = !(dout_valid && !dout_ready);
    assign din_ready = w_adv;

    // Stage E: priority encode
    logic [INT_WIDTH-1:0] w_msb;
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < DIN_WIDTH; i++) begin
            if (din[i]) w_msb = INT_WIDTH'(i);
        end
    end

    logic                 r_e_valid, r_e_zero;
    logic [DIN_WIDTH-1:0] r_e_din;
    logic [INT_WIDTH-1:0] r_e_msb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_e_valid <= 1'b0;
            r_e_din   <= '0;
            r_e_msb   <= '0;
            r_e_zero  <= 1'b0;
        end else if (w_adv) begin
            r_e_valid <= din_valid;
            if (din_valid) begin
                r_e_din  <= din;
                r_e_msb  <= w_msb;
                r_e_zero <= (din == '0);
            end
        end
    end

    // Stage N: normalise so the leading one lands on the mantissa MSB
    logic [INT_WIDTH-1:0]  w_shamt;
    logic [DIN_WIDTH-1:0]  w_shift;
    logic [MANT_WIDTH-1:0] w_mant;

    assign w_shamt = INT_WIDTH'(DIN_WIDTH - 1) - r_e_msb;
    assign w_shift = r_e_din << w_shamt;

    generate
        if (DIN_WIDTH >= MANT_WIDTH) begin : g_mant_trunc
            assign w_mant = MANT_WIDTH'(w_shift >> (DIN_WIDTH - MANT_WIDTH));
        end else begin : g_mant_pad
            assign w_mant = {w_shift, {(MANT_WIDTH - DIN_WIDTH){1'b0}}};
        end
    endgenerate

    logic                  r_n_valid, r_n_zero;
    logic [INT_WIDTH-1:0]  r_n_msb;
    logic [MANT_WIDTH-1:0] r_n_m;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n_valid <= 1'b0;
            r_n_zero  <= 1'b0;
            r_n_msb   <= '0;
            r_n_m     <= '0;
        end else if (w_adv) begin
            r_n_valid <= r_e_valid;
            r_n_zero  <= r_e_zero;
            r_n_msb   <= r_e_msb;
            r_n_m     <= w_mant;
        end
    end

    // Stages F: each squares m; an overflow past 2 yields a 1 bit and halves m
    logic [NBITS-1:0]        r_f_valid, r_f_zero;
    logic [INT_WIDTH-1:0]    r_f_msb  [NBITS];
    logic [MANT_WIDTH-1:0]   r_f_m    [NBITS];
    logic [NBITS-1:0]        r_f_bits [NBITS];

    logic [NBITS-1:0]        w_src_valid, w_src_zero, w_bit;
    logic [INT_WIDTH-1:0]    w_src_msb   [NBITS];
    logic [MANT_WIDTH-1:0]   w_src_m     [NBITS];
    logic [MANT_WIDTH-1:0]   w_m_next    [NBITS];
    logic [NBITS-1:0]        w_src_bits  [NBITS];
    logic [NBITS-1:0]        w_bits_next [NBITS];
    logic [2*MANT_WIDTH-1:0] w_p         [NBITS];

    always_comb begin
        w_src_valid    = '0;
        w_src_zero     = '0;
        w_bit          = '0;
        w_src_valid[0] = r_n_valid;
        w_src_zero[0]  = r_n_zero;
        w_src_msb[0]   = r_n_msb;
        w_src_m[0]     = r_n_m;
        w_src_bits[0]  = '0;
        for (int s = 1; s < NBITS; s++) begin
            w_src_valid[s] = r_f_valid[s-1];
            w_src_zero[s]  = r_f_zero[s-1];
            w_src_msb[s]   = r_f_msb[s-1];
            w_src_m[s]     = r_f_m[s-1];
            w_src_bits[s]  = r_f_bits[s-1];
        end
        for (int s = 0; s < NBITS; s++) begin
            w_p[s]         = {{MANT_WIDTH{1'b0}}, w_src_m[s]} * {{MANT_WIDTH{1'b0}}, w_src_m[s]};
            w_bit[s]       = w_p[s][2*MANT_WIDTH-1];
            w_m_next[s]    = w_bit[s] ? MANT_WIDTH'(w_p[s] >> MANT_WIDTH)
                                      : MANT_WIDTH'(w_p[s] >> (MANT_WIDTH - 1));
            w_bits_next[s] = w_src_bits[s];
            w_bits_next[s][NBITS-1-s] = w_bit[s];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_f_valid <= '0;
            r_f_zero  <= '0;
            for (int s = 0; s < NBITS; s++) begin
                r_f_msb[s]  <= '0;
                r_f_m[s]    <= '0;
                r_f_bits[s] <= '0;
            end
        end else if (w_adv) begin
            r_f_valid <= w_src_valid;
            r_f_zero  <= w_src_zero;
            for (int s = 0; s < NBITS; s++) begin
                r_f_msb[s]  <= w_src_msb[s];
                r_f_m[s]    <= w_m_next[s];
                r_f_bits[s] <= w_bits_next[s];
            end
        end
    end

    logic             w_res_valid, w_res_zero;
    logic [OUT_W-1:0] w_res;

`ifdef MATH_LOG2_ROUND_EN
    // Half-up on the extra bit; carry may ripple into int, full overflow saturates
    logic [OUT_W:0]   w_sum;
    logic             r_r_valid, r_r_zero;
    logic [OUT_W-1:0] r_r_res;

    assign w_sum = {1'b0, r_f_msb[NBITS-1], r_f_bits[NBITS-1][NBITS-1:1]}
                 + {{OUT_W{1'b0}}, r_f_bits[NBITS-1][0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_r_valid <= 1'b0;
            r_r_zero  <= 1'b0;
            r_r_res   <= '0;
        end else if (w_adv) begin
            r_r_valid <= r_f_valid[NBITS-1];
            r_r_zero  <= r_f_zero[NBITS-1];
            r_r_res   <= w_sum[OUT_W] ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
        end
    end

    assign w_res_valid = r_r_valid;
    assign w_res_zero  = r_r_zero;
    assign w_res       = r_r_res;
`else
    assign w_res_valid = r_f_valid[NBITS-1];
    assign w_res_zero  = r_f_zero[NBITS-1];
    assign w_res       = {r_f_msb[NBITS-1], r_f_bits[NBITS-1]};
`endif

    logic             r_o_valid, r_o_zero;
    logic [OUT_W-1:0] r_o_dout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_o_valid <= 1'b0;
            r_o_zero  <= 1'b0;
            r_o_dout  <= '0;
        end else if (w_adv) begin
            r_o_valid <= w_res_valid;
            r_o_zero  <= w_res_zero;
            r_o_dout  <= w_res_zero ? '0 : w_res;
        end
    end

    assign dout_valid = r_o_valid;
    assign dout_zero  = r_o_zero;
    assign dout       = r_o_dout;

endmodule

// File: tb/tb_math_log2_pipe.sv
// tb/tb_math_log2_pipe.sv - scoreboard bench for math_log2_pipe at default parameters
module tb_math_log2_pipe;

    localparam int DW = 64;
    localparam int OW = 10;
`ifdef MATH_LOG2_ROUND_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 6;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          din_valid = 1'b0;
    logic          dout_ready = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_ready, dout_valid, dout_zero;
    logic [OW-1:0] dout;

    typedef struct packed {
        logic [OW-1:0] v;
        logic          z;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    math_log2_pipe dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_zero  (dout_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [DW-1:0] d);
        int  m = 0;
        int  fb;
        int  val;
        real f;
        for (int i = 0; i < DW; i++) if (d[i]) m = i;
        f = $ln(real'(d)) / $ln(2.0) - real'(m);
        if (f < 0.0) f = 0.0;
`ifdef MATH_LOG2_ROUND_EN
        fb = int'($floor(f * 32.0));
        fb = (fb + 1) >> 1;
`else
        fb = int'($floor(f * 16.0));
`endif
        val = m * 16 + fb;
        if (val > 1023) val = 1023;
        return OW'(val);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_dout = '0;
    logic          prev_z = 1'b0;
    exp_t          e;

    always @(negedge clk) begin
        check("din_ready", 32'(din_ready), 32'(!(dout_valid && !dout_ready)));
        if (rstn && prev_stall) begin
            check("hold_valid", 32'(dout_valid), 32'd1);
            check("hold_dout", {21'd0, dout_zero, dout}, {21'd0, prev_z, prev_dout});
        end
        if (rstn && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'(dout_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("dout", 32'(dout), 32'(e.v));
                check("dout_zero", 32'(dout_zero), 32'(e.z));
            end
        end
        prev_stall = rstn && dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_z     = dout_zero;
    end

    task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] v, input logic z);
        bit acc = 1'b0;
        din       = d;
        din_valid = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = din_ready;
            if (acc) q.push_back('{v: v, z: z});
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'(din_ready), 32'd1);
        din_valid = 1'b0;
        din       = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    int cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_zero", 32'(dout_zero), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(dout_valid), 32'd0);
        check("post_rst_ready", 32'(din_ready), 32'd1);

        send(64'd1, 10'h000, 1'b0);
        cyc = 0;
        while (!dout_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(LAT));
        drain();

        send(64'd1 << 10, 10'h0A0, 1'b0);
        send(64'd1 << 63, 10'h3F0, 1'b0);
        send(64'd3, 10'h019, 1'b0);
        send({DW{1'b1}}, 10'h3FF, 1'b0);
        send(64'd5, 10'h025, 1'b0);
        send(64'd0, 10'h000, 1'b1);
        send(64'd6, 10'h029, 1'b0);
        drain();

        rdy_mode = 1;
        for (int d = 1; d <= 20; d++) send(DW'(d), model(DW'(d)), 1'b0);
        drain();
        rdy_mode = 0;

        rdy_mode = 2;
        for (int d = 9; d <= 12; d++) send(DW'(d), model(DW'(d)), 1'b0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("stalled_valid", 32'(dout_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(dout_valid), 32'd0);
        q.delete();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check("no_stale_valid", 32'(dout_valid), 32'd0);
        send(64'd7, model(64'd7), 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
